// File: rtl/pwm_capture.sv
// PWM duty recovery: measures high time between rising edges, flags bad periods and stuck lines.
// Optional 3-sample majority glitch filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int DATA_W  = 8,
    parameter int PER_TOL = 0
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [DATA_W-1:0] duty_out,
    output logic              duty_valid,
    output logic              period_err,
    output logic              stuck_lo,
    output logic              stuck_hi
);
    localparam int CW     = DATA_W + 2;
    localparam int PERIOD = 2 ** DATA_W;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] PER_LO   = CW'(PERIOD - PER_TOL);
    localparam logic [CW-1:0] PER_HI   = CW'(PERIOD + PER_TOL);
    localparam logic [CW-1:0] TO_LIM   = CW'(PERIOD + PER_TOL + 2);
    localparam logic [CW-1:0] DUTY_MAX = CW'(PERIOD - 1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d, s_dly_q, s_dly_d;
    logic [CW-1:0]     per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
    logic [DATA_W-1:0] duty_q, duty_d;
    logic              valid_q, valid_d, err_q, err_d;
    logic              slo_q, slo_d, shi_q, shi_d;
    logic [CW-1:0]     per_inc, hi_inc;
    logic              s, rise, in_tol;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic h1_q, h1_d, h2_q, h2_d;
    assign s = (sync2_q & h1_q) | (sync2_q & h2_q) | (h1_q & h2_q);
`else
    assign s = sync2_q;
`endif

    assign rise    = s & ~s_dly_q;
    assign per_inc = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + ONE;
    assign hi_inc  = (hi_cnt_q == '1 || !s) ? hi_cnt_q : hi_cnt_q + ONE;
    assign in_tol  = (per_cnt_q >= PER_LO) && (per_cnt_q <= PER_HI);

    always_comb begin
        sync1_d   = pwm_in;
        sync2_d   = sync1_q;
        s_dly_d   = s;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        h1_d      = sync2_q;
        h2_d      = h1_q;
`endif
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        slo_d     = slo_q;
        shi_d     = shi_q;

        if (rise) begin
            // A rise in IDLE only opens a period; in MEASURE it also closes the previous one.
            state_d   = MEASURE;
            per_cnt_d = ONE;
            hi_cnt_d  = ONE;
            slo_d     = 1'b0;
            shi_d     = 1'b0;
            if (state_q == MEASURE) begin
                if (in_tol) begin
                    duty_d  = (hi_cnt_q > DUTY_MAX) ? '1 : hi_cnt_q[DATA_W-1:0];
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (!slo_q && !shi_q) begin
            // Stuck flags imply IDLE, so counting stops until the next rise.
            if (per_cnt_q >= TO_LIM) begin
                state_d   = IDLE;
                per_cnt_d = '0;
                hi_cnt_d  = '0;
                valid_d   = 1'b1;
                slo_d     = ~s;
                shi_d     = s;
                duty_d    = {DATA_W{s}};
            end else begin
                per_cnt_d = per_inc;
                if (state_q == MEASURE) hi_cnt_d = hi_inc;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            s_dly_q   <= 1'b0;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
            h1_q      <= 1'b0;
            h2_q      <= 1'b0;
`endif
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            slo_q     <= 1'b0;
            shi_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            s_dly_q   <= s_dly_d;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
            h1_q      <= h1_d;
            h2_q      <= h2_d;
`endif
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            slo_q     <= slo_d;
            shi_q     <= shi_d;
        end
    end

    assign duty_out   = duty_q;
    assign duty_valid = valid_q;
    assign period_err = err_q;
    assign stuck_lo   = slo_q;
    assign stuck_hi   = shi_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a period-level model predicts each report, a monitor checks them.
`timescale 1ns/1ps
module tb_pwm_capture;
    localparam int DATA_W  = 8;
    localparam int PER_TOL = 0;
    localparam int PERIOD  = 256;
    localparam int DMAX    = 255;

    logic              clk_in = 1'b0;
    logic              rst_n  = 1'b0;
    logic              pwm_in = 1'b0;
    logic [DATA_W-1:0] duty_out;
    logic              duty_valid, period_err, stuck_lo, stuck_hi;

    always #5 clk_in = ~clk_in;

    pwm_capture #(.DATA_W(DATA_W), .PER_TOL(PER_TOL)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .pwm_in(pwm_in),
        .duty_out(duty_out), .duty_valid(duty_valid), .period_err(period_err),
        .stuck_lo(stuck_lo), .stuck_hi(stuck_hi)
    );

    typedef struct {
        bit is_err;
        int duty;
        bit slo;
        bit shi;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: what the receiver has seen, in terms of whole periods.
    bit armed = 0;
    bit stuck_m = 0;
    bit line = 0;
    int cur_h = 0;
    int cur_l = 0;
    int last_duty = 0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // A rising edge on the line closes the previously opened period, if any.
    task automatic on_rise();
        exp_t e;
        if (armed) begin
            if (cur_l >= PERIOD - PER_TOL && cur_l <= PERIOD + PER_TOL) begin
                e.is_err  = 0;
                e.duty    = (cur_h > DMAX) ? DMAX : cur_h;
                last_duty = e.duty;
            end else begin
                e.is_err = 1;
                e.duty   = last_duty;
            end
            e.slo = 0;
            e.shi = 0;
            exp_q.push_back(e);
        end
        armed   = 1;
        stuck_m = 0;
    endtask

    task automatic drive_period(input int h, input int l);
        if (!line) on_rise();
        cur_h  = h;
        cur_l  = l;
        pwm_in = 1'b1;
        line   = 1;
        repeat (h) @(negedge clk_in);
        pwm_in = 1'b0;
        line   = 0;
        repeat (l - h) @(negedge clk_in);
    endtask

    // Hold the line long enough (n >= 300) that the receiver must declare it stuck.
    task automatic hold(input bit lvl, input int n);
        exp_t e;
        if (lvl && !line) on_rise();
        pwm_in = lvl;
        line   = lvl;
        if (!stuck_m) begin
            e.is_err  = 0;
            e.duty    = lvl ? DMAX : 0;
            e.slo     = !lvl;
            e.shi     = lvl;
            last_duty = e.duty;
            exp_q.push_back(e);
        end
        stuck_m = 1;
        armed   = 0;
        repeat (n) @(negedge clk_in);
    endtask

    // Monitor: every report is popped against the oldest prediction.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n) begin
            check("exclusive_flags", int'((duty_valid && period_err) || (stuck_lo && stuck_hi)), 0);
            if (duty_valid || period_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_report", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("report_kind", int'(period_err), int'(e.is_err));
                    check("duty_out", int'(duty_out), e.duty);
                    check("stuck_lo", int'(stuck_lo), int'(e.slo));
                    check("stuck_hi", int'(stuck_hi), int'(e.shi));
                end
            end
        end
    end

    initial begin
        #2;
        check("rst_duty_out", int'(duty_out), 0);
        check("rst_duty_valid", int'(duty_valid), 0);
        check("rst_period_err", int'(period_err), 0);
        check("rst_stuck_lo", int'(stuck_lo), 0);
        check("rst_stuck_hi", int'(stuck_hi), 0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;

        // Line low from reset -> stuck low, then recovery with duty 50.
        hold(0, 300);
        check("stuck_lo_level", int'(stuck_lo), 1);
        drive_period(50, 256);
        check("stuck_lo_cleared", int'(stuck_lo), 0);
        drive_period(50, 256);
        drive_period(50, 256);

        for (int i = 0; i < 4; i++) drive_period(100, 256);

        // Random duty sweep, including extremes.
        drive_period(1, 256);
        drive_period(255, 256);
        for (int i = 0; i < 40; i++) drive_period($urandom_range(1, 255), 256);

        // Bad period lengths interleaved with good ones.
        for (int i = 0; i < 8; i++) begin
            int l;
            int h;
            drive_period($urandom_range(1, 255), 256);
            l = ($urandom_range(0, 3) == 0) ? 257 : $urandom_range(150, 255);
            h = $urandom_range(1, l - 1);
            if (h > DMAX) h = DMAX;
            drive_period(h, l);
        end

        // Line high -> stuck high, recover, then short periods must hold duty_out.
        drive_period(77, 256);
        hold(1, 400);
        check("stuck_hi_level", int'(stuck_hi), 1);
        pwm_in = 1'b0;
        line   = 0;
        repeat (20) @(negedge clk_in);
        drive_period(100, 256);
        check("stuck_hi_cleared", int'(stuck_hi), 0);
        drive_period(100, 256);
        for (int i = 0; i < 3; i++) drive_period(100, 200);
        drive_period(100, 256);

        // Async reset mid-period discards the partial measurement.
        on_rise();
        cur_h  = 100;
        cur_l  = 256;
        pwm_in = 1'b1;
        line   = 1;
        repeat (100) @(negedge clk_in);
        pwm_in = 1'b0;
        line   = 0;
        repeat (60) @(negedge clk_in);
        check("pre_reset_drain", exp_q.size(), 0);
        #3 rst_n = 1'b0;
        #0.5;
        check("arst_duty_out", int'(duty_out), 0);
        check("arst_duty_valid", int'(duty_valid), 0);
        check("arst_period_err", int'(period_err), 0);
        check("arst_stuck_lo", int'(stuck_lo), 0);
        check("arst_stuck_hi", int'(stuck_hi), 0);
        #0.5 rst_n = 1'b1;
        armed     = 0;
        stuck_m   = 0;
        last_duty = 0;
        @(negedge clk_in);
        repeat (90) @(negedge clk_in);
        for (int i = 0; i < 3; i++) drive_period(100, 256);

        hold(0, 400);
        check("final_stuck_lo", int'(stuck_lo), 1);

        for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(negedge clk_in);
        check("all_reports_seen", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
